// File: rtl/mem_seq_pkg.sv
// Shared types for the EX/MEM request sequencer.
// Request opcodes, sequencer states and default widths.
package mem_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 32;
  localparam int FLAGS_W    = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_INT   = 3'd7
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ1 = 2'd1,
    ST_SEQ2 = 2'd2
  } state_e;

endpackage

// File: rtl/mem_request_sequencer.sv
// Splits EX/MEM requests into memory-stage strobes; CALL/RET/INT take two words.
// Define INT_FLAGS_PUSH_EN to make INT also push the CCR flags first (3 words).
module mem_request_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [3:0]        req_flags,
  input  logic [DATA_W-1:0] mem_data,
  output logic              memory_read,
  output logic              memory_write,
  output logic              memory_push,
  output logic              memory_pop,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              result_valid,
  output logic [PC_W-1:0]   result_data
);

  state_e              r_state;
  state_e              w_next;
  req_op_e             r_op;
  req_op_e             w_op;
  logic [DATA_W-1:0]   r_pc_lo;
`ifdef INT_FLAGS_PUSH_EN
  logic [DATA_W-1:0]   r_pc_hi;
`endif
  logic [DATA_W-1:0]   r_low;
  logic                r_res_valid;
  logic [PC_W-1:0]     r_res_data;

  logic                w_rd;
  logic                w_wr;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_stall;
  logic                w_cap;
  logic                w_cap_low;
  logic                w_res_word;
  logic                w_res_ret;

  assign w_op = req_op_e'(req_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_stall    = 1'b0;
    w_cap      = 1'b0;
    w_cap_low  = 1'b0;
    w_res_word = 1'b0;
    w_res_ret  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (w_op)
            OP_LOAD: begin
              w_rd       = 1'b1;
              w_addr     = req_addr;
              w_res_word = 1'b1;
            end
            OP_STORE: begin
              w_wr    = 1'b1;
              w_addr  = req_addr;
              w_wdata = req_data;
            end
            OP_PUSH: begin
              w_push  = 1'b1;
              w_wdata = req_data;
            end
            OP_POP: begin
              w_pop      = 1'b1;
              w_res_word = 1'b1;
            end
            OP_CALL: begin
              w_push  = 1'b1;
              w_wdata = req_pc[PC_W-1:DATA_W];
              w_stall = 1'b1;
              w_cap   = 1'b1;
              w_next  = ST_SEQ1;
            end
            OP_RET: begin
              w_pop     = 1'b1;
              w_stall   = 1'b1;
              w_cap     = 1'b1;
              w_cap_low = 1'b1;
              w_next    = ST_SEQ1;
            end
            OP_INT: begin
              w_push  = 1'b1;
`ifdef INT_FLAGS_PUSH_EN
              w_wdata = DATA_W'(req_flags);
`else
              w_wdata = req_pc[PC_W-1:DATA_W];
`endif
              w_stall = 1'b1;
              w_cap   = 1'b1;
              w_next  = ST_SEQ1;
            end
            default: begin
            end
          endcase
        end
      end
      ST_SEQ1: begin
        w_next = ST_IDLE;
        if (r_op == OP_RET) begin
          w_pop     = 1'b1;
          w_res_ret = 1'b1;
`ifdef INT_FLAGS_PUSH_EN
        end else if (r_op == OP_INT) begin
          w_push  = 1'b1;
          w_wdata = r_pc_hi;
          w_stall = 1'b1;
          w_next  = ST_SEQ2;
`endif
        end else begin
          w_push  = 1'b1;
          w_wdata = r_pc_lo;
        end
      end
`ifdef INT_FLAGS_PUSH_EN
      ST_SEQ2: begin
        w_push  = 1'b1;
        w_wdata = r_pc_lo;
        w_next  = ST_IDLE;
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Latched operands: later words never look at req_* again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_NOP;
      r_pc_lo <= '0;
`ifdef INT_FLAGS_PUSH_EN
      r_pc_hi <= '0;
`endif
      r_low   <= '0;
    end else begin
      if (w_cap) begin
        r_op    <= w_op;
        r_pc_lo <= req_pc[DATA_W-1:0];
`ifdef INT_FLAGS_PUSH_EN
        r_pc_hi <= req_pc[PC_W-1:DATA_W];
`endif
      end
      if (w_cap_low) begin
        r_low <= mem_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= w_res_word | w_res_ret;
      if (w_res_word) begin
        r_res_data <= PC_W'(mem_data);
      end else if (w_res_ret) begin
        r_res_data <= {mem_data, r_low};
      end
    end
  end

  // Reset silences the strobes combinationally, not only at the next edge.
  assign memory_read  = w_rd   & ~rst;
  assign memory_write = w_wr   & ~rst;
  assign memory_push  = w_push & ~rst;
  assign memory_pop   = w_pop  & ~rst;
  assign stall        = w_stall & ~rst;
  assign address      = w_addr;
  assign write_data   = w_wdata;
  assign result_valid = r_res_valid;
  assign result_data  = r_res_data;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Randomized bench for mem_request_sequencer with a per-request beat model.
// Honors INT_FLAGS_PUSH_EN the same way as the design build.
module tb_mem_request_sequencer;
  import mem_seq_pkg::*;

  localparam int DW = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [PW-1:0] req_pc;
  logic [3:0]    req_flags;
  logic [DW-1:0] mem_data;
  logic          memory_read;
  logic          memory_write;
  logic          memory_push;
  logic          memory_pop;
  logic [DW-1:0] address;
  logic [DW-1:0] write_data;
  logic          stall;
  logic          result_valid;
  logic [PW-1:0] result_data;

  always #5 clk = ~clk;

  mem_request_sequencer #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .req_pc(req_pc), .req_flags(req_flags),
    .mem_data(mem_data),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .address(address), .write_data(write_data),
    .stall(stall),
    .result_valid(result_valid), .result_data(result_data)
  );

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          ps;
    logic          pp;
    logic [DW-1:0] addr;
    logic [DW-1:0] wd;
    logic          st;
  } beat_t;

  int            checks = 0;
  int            failures = 0;
  logic          exp_en = 1'b0;
  beat_t         exp_b = '0;
  logic          exp_rv = 1'b0;
  logic [PW-1:0] exp_rd = '0;
  logic          pend_rv = 1'b0;
  logic [PW-1:0] pend_rd = '0;
  logic [DW-1:0] push_log [$];
  int            stall_cnt = 0;
  int            rv_cnt = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Spec-level expansion of one request into its memory-stage beats.
  function automatic int model(input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] d, input logic [PW-1:0] pc,
                               input logic [3:0] fl, output beat_t [2:0] b);
    b = '0;
    unique case (op)
      OP_LOAD:  begin b[0].rd = 1; b[0].addr = a; return 1; end
      OP_STORE: begin b[0].wr = 1; b[0].addr = a; b[0].wd = d; return 1; end
      OP_PUSH:  begin b[0].ps = 1; b[0].wd = d; return 1; end
      OP_POP:   begin b[0].pp = 1; return 1; end
      OP_RET:   begin b[0].pp = 1; b[0].st = 1; b[1].pp = 1; return 2; end
`ifdef INT_FLAGS_PUSH_EN
      OP_INT: begin
        b[0].ps = 1; b[0].st = 1; b[0].wd = {12'h000, fl};
        b[1].ps = 1; b[1].st = 1; b[1].wd = pc[31:16];
        b[2].ps = 1; b[2].wd = pc[15:0];
        return 3;
      end
`endif
      OP_CALL, OP_INT: begin
        b[0].ps = 1; b[0].st = 1; b[0].wd = pc[31:16];
        b[1].ps = 1; b[1].wd = pc[15:0];
        return 2;
      end
      default: return 1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (memory_push) push_log.push_back(write_data);
      if (stall) stall_cnt++;
      if (result_valid) rv_cnt++;
    end
    if (exp_en) begin
      chk("rd", 32'(memory_read), 32'(exp_b.rd));
      chk("wr", 32'(memory_write), 32'(exp_b.wr));
      chk("push", 32'(memory_push), 32'(exp_b.ps));
      chk("pop", 32'(memory_pop), 32'(exp_b.pp));
      chk("onehot0", 32'($onehot0({memory_read, memory_write,
                                   memory_push, memory_pop})), 32'd1);
      chk("stall", 32'(stall), 32'(exp_b.st));
      if (exp_b.rd || exp_b.wr) chk("address", 32'(address), 32'(exp_b.addr));
      if (exp_b.wr || exp_b.ps) chk("wdata", 32'(write_data), 32'(exp_b.wd));
      chk("rvalid", 32'(result_valid), 32'(exp_rv));
      if (exp_rv) chk("rdata", result_data, exp_rd);
    end
  end

  task automatic do_req(input logic v, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic [PW-1:0] pc, input logic [3:0] fl,
                        input bit fix, input logic [DW-1:0] m0,
                        input logic [DW-1:0] m1);
    beat_t [2:0]   b;
    int            n;
    logic [DW-1:0] md;
    logic [DW-1:0] lo;
    lo = '0;
    n = model(v ? op : 3'd0, a, d, pc, fl, b);
    req_valid = v; req_op = op; req_addr = a; req_data = d;
    req_pc = pc; req_flags = fl;
    for (int i = 0; i < n; i++) begin
      md = fix ? ((i == 0) ? m0 : m1) : DW'($urandom);
      if (i > 0) begin
        req_addr = DW'($urandom); req_data = DW'($urandom);
        req_pc = $urandom; req_flags = 4'($urandom);
      end
      mem_data = md;
      exp_b = b[i]; exp_rv = pend_rv; exp_rd = pend_rd; exp_en = 1'b1;
      pend_rv = 1'b0;
      if (v && (op == OP_LOAD || op == OP_POP)) begin
        pend_rv = 1'b1; pend_rd = PW'(md);
      end
      if (v && op == OP_RET) begin
        if (i == 0) lo = md;
        else begin pend_rv = 1'b1; pend_rd = {md, lo}; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    do_req(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [2:0] rop;
    rst = 1'b1; req_valid = 0; req_op = 0; req_addr = 0; req_data = 0;
    req_pc = 0; req_flags = 0; mem_data = 0;
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_rdata", result_data, 32'd0);
    chk("rst_strobes", 32'({memory_read, memory_write, memory_push,
                            memory_pop}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();

    do_req(1, OP_LOAD, 16'h0010, 16'h0, 0, 0, 1, 16'hBEEF, 16'h0);
    chk("pin_load_rv", 32'(result_valid), 32'd1);
    chk("pin_load_rd", result_data, 32'h0000BEEF);
    idle();

    push_log.delete(); stall_cnt = 0;
    do_req(1, OP_CALL, 0, 0, 32'h12345678, 0, 0, 0, 0);
    idle();
    chk("pin_call_n", 32'(push_log.size()), 32'd2);
    if (push_log.size() == 2) begin
      chk("pin_call_w0", 32'(push_log[0]), 32'h1234);
      chk("pin_call_w1", 32'(push_log[1]), 32'h5678);
    end
    chk("pin_call_stall", 32'(stall_cnt), 32'd1);

    stall_cnt = 0; rv_cnt = 0;
    do_req(1, OP_RET, 0, 0, 0, 0, 1, 16'h5678, 16'h1234);
    chk("pin_ret_rd", result_data, 32'h12345678);
    idle(); idle();
    chk("pin_ret_stall", 32'(stall_cnt), 32'd1);
    chk("pin_ret_pulses", 32'(rv_cnt), 32'd1);

    push_log.delete(); stall_cnt = 0;
    do_req(1, OP_INT, 0, 0, 32'h00000040, 4'hA, 0, 0, 0);
    idle();
`ifdef INT_FLAGS_PUSH_EN
    chk("pin_int_n", 32'(push_log.size()), 32'd3);
    if (push_log.size() == 3) begin
      chk("pin_int_w0", 32'(push_log[0]), 32'h000A);
      chk("pin_int_w1", 32'(push_log[1]), 32'h0000);
      chk("pin_int_w2", 32'(push_log[2]), 32'h0040);
    end
    chk("pin_int_stall", 32'(stall_cnt), 32'd2);
`else
    chk("pin_int_n", 32'(push_log.size()), 32'd2);
    if (push_log.size() == 2) begin
      chk("pin_int_w0", 32'(push_log[0]), 32'h0000);
      chk("pin_int_w1", 32'(push_log[1]), 32'h0040);
    end
    chk("pin_int_stall", 32'(stall_cnt), 32'd1);
`endif

    stall_cnt = 0;
    do_req(1, OP_STORE, 16'h0020, 16'h1111, 0, 0, 0, 0, 0);
    do_req(1, OP_PUSH, 0, 16'h2222, 0, 0, 0, 0, 0);
    do_req(1, OP_POP, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("b2b_stall", 32'(stall_cnt), 32'd0);

    // Reset in the second beat of RET abandons it.
    rv_cnt = 0;
    req_valid = 1; req_op = OP_RET; mem_data = 16'h9999;
    exp_b = '0; exp_b.pp = 1; exp_b.st = 1;
    exp_rv = pend_rv; exp_rd = pend_rd; exp_en = 1;
    @(posedge clk); #1;
    exp_en = 0;
    chk("rst_seq1_pop", 32'(memory_pop), 32'd1);
    rst = 1'b1; #1;
    chk("rst_seq1_strobes", 32'({memory_read, memory_write, memory_push,
                                 memory_pop}), 32'd0);
    chk("rst_seq1_stall", 32'(stall), 32'd0);
    chk("rst_seq1_rv", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; pend_rv = 1'b0;
    idle();
    chk("rst_seq1_norv", 32'(rv_cnt), 32'd0);
    do_req(1, OP_LOAD, 16'h0044, 0, 0, 0, 1, 16'h0ABC, 0);
    chk("after_rst_load", result_data, 32'h00000ABC);

    for (int k = 0; k < 400; k++) begin
      rop = 3'($urandom_range(0, 7));
      do_req(($urandom_range(0, 9) != 0), rop, DW'($urandom), DW'($urandom),
             $urandom, 4'($urandom), 1'b0, '0, '0);
    end
    idle();
    exp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_request_sequencer.md
MEM_REQUEST_SEQUENCER -- requirements
Module: mem_request_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: memory word width.
REQ-002 Parameter PC_W, default 32: program counter width; SHALL equal 2*DATA_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  EX/MEM request present this cycle.
REQ-006 req_op  input  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 INT.
REQ-007 req_addr  input  DATA_W  LOAD/STORE address.
REQ-008 req_data  input  DATA_W  STORE/PUSH data.
REQ-009 req_pc  input  PC_W  return PC for CALL/INT.
REQ-010 req_flags  input  4  CCR flags for INT.
REQ-011 mem_data  input  DATA_W  read data returned by the memory stage in the same cycle.
REQ-012 memory_read, memory_write, memory_push, memory_pop  output  1 each  memory-stage command strobes.
REQ-013 address, write_data  output  DATA_W each  memory-stage operands.
REQ-014 stall  output  1  upstream holds the request and its operands stable while high.
REQ-015 result_valid  output  1  one-cycle pulse: result_data valid.
REQ-016 result_data  output  PC_W  loaded/popped word, zero-extended, or assembled PC.

Function
REQ-017 States: IDLE, SEQ1, SEQ2; SEQ2 SHALL be reachable only when INT_FLAGS_PUSH_EN is defined.
REQ-018 In IDLE, strobes, address and write_data SHALL be decoded combinationally from req_*; req_valid=0, NOP, or any undefined code SHALL produce all strobes 0, stall 0.
REQ-019 At most one strobe SHALL be high in any cycle.
REQ-020 LOAD: memory_read=1, address=req_addr; mem_data SHALL be registered at the clock edge; result_valid=1 with result_data={16'b0,word} in the next cycle.
REQ-021 STORE: memory_write=1, address=req_addr, write_data=req_data; no result.
REQ-022 PUSH: memory_push=1, write_data=req_data. POP: memory_pop=1; result as for LOAD.
REQ-023 CALL: IDLE cycle pushes req_pc[31:16], stall=1, next SEQ1; SEQ1 pushes req_pc[15:0], stall=0, next IDLE.
REQ-024 RET: IDLE cycle pops the low half, stall=1, next SEQ1; SEQ1 pops the high half, stall=0, next IDLE; result_valid in the following cycle with result_data={high,low}.
REQ-025 INT without the macro SHALL behave exactly as CALL.
REQ-026 req_pc and req_flags SHALL be latched on the IDLE cycle of a multi-cycle op; later words SHALL use the latched copies.
REQ-027 req_valid or req_op changing while stall=1 is a protocol violation; the sequencer SHALL ignore inputs other than mem_data outside IDLE.
REQ-028 Back-to-back single-cycle ops SHALL issue one per cycle with stall=0.

Reset
REQ-029 On rst: state IDLE, stall 0, result_valid 0, result_data 0, latched PC/flags/low word 0, immediately and independent of clk.
REQ-030 rst during SEQ1/SEQ2 SHALL abandon the sequence; no further strobes and no result_valid for it.

Configuration
REQ-031 Macro INT_FLAGS_PUSH_EN defined: INT pushes {12'b0,req_flags} in IDLE (stall=1, next SEQ1), PC[31:16] in SEQ1 (stall=1, next SEQ2), PC[15:0] in SEQ2 (stall=0, next IDLE).
REQ-032 Macro undefined: no SEQ2 logic; REQ-025 applies.

Structure
REQ-033 Package mem_seq_pkg SHALL hold the req_op enum, state enum, DATA_W/PC_W defaults.
REQ-034 Single module; no sub-module.

Verification
REQ-035 LOAD addr 0x0010 with mem_data 0xBEEF -> memory_read 1 cycle, next cycle result_valid=1, result_data 0x0000BEEF.
REQ-036 CALL req_pc 0x12345678 -> push 0x1234 then 0x5678, stall high exactly 1 cycle.
REQ-037 RET with mem_data 0x5678 then 0x1234 -> two pops, stall 1 cycle, result_data 0x12345678 pulsed once.
REQ-038 INT flags 0xA, pc 0x00000040, macro defined -> pushes 0x000A, 0x0000, 0x0040, stall 2 cycles; undefined -> 0x0000, 0x0040.
REQ-039 rst asserted in SEQ1 of RET -> strobes drop at once, no result_valid, next request served from IDLE.
REQ-040 STORE, PUSH, POP back-to-back -> one strobe per cycle, stall never high, onehot-or-zero strobes every cycle.
